// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the IF/MEM unified-memory port arbiter.
// State encodings, port ids and the saturating-increment helper live here.
package mem_port_arbiter_pkg;

    localparam int WORD_WIDTH      = 32;
    localparam int ARB_WAIT_CYCLES = 2;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_PORT_IF  = 1'b0,
        ARB_PORT_MEM = 1'b1
    } arb_port_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side bundle of the arbiter: IF fetch port, MEM load/store port, freeze.
// master = pipeline stages, slave = arbiter.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = WORD_WIDTH
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              freeze;

    modport master (
        output if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready, freeze
    );

    modport slave (
        input  if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata,
        output if_rdata, if_ready, mem_rdata, mem_ready, freeze
    );
endinterface

// File: rtl/mem_port_arb_stats.sv
// Saturating grant/conflict counters for the memory port arbiter.
// Compiled in only when MEM_PORT_ARB_STATS_EN is defined.
`ifdef MEM_PORT_ARB_STATS_EN
module mem_port_arb_stats
    import mem_port_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_grant,
    input  logic        mem_grant,
    input  logic        if_conflict,
    output logic [31:0] stat_if_grants,
    output logic [31:0] stat_mem_grants,
    output logic [31:0] stat_conflicts
);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_if_grants  <= '0;
            stat_mem_grants <= '0;
            stat_conflicts  <= '0;
        end else begin
            if (if_grant)    stat_if_grants  <= sat_inc(stat_if_grants);
            if (mem_grant)   stat_mem_grants <= sat_inc(stat_mem_grants);
            if (if_conflict) stat_conflicts  <= sat_inc(stat_conflicts);
        end
    end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Fixed-priority (MEM > IF) arbiter sharing one fixed-latency memory between fetch and load/store.
// Optional statistics counters enabled by MEM_PORT_ARB_STATS_EN; otherwise stat_* read as zero.
//
// state      | meaning
// ARB_IDLE   | no access in flight; grant decision made this cycle
// ARB_ACCESS | ram_en held WAIT_CYCLES cycles; read data captured in last one
// ARB_RESP   | ram idle, ready pulse to the granted port
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = WORD_WIDTH,
    parameter int WAIT_CYCLES = ARB_WAIT_CYCLES
)
(
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [31:0]       stat_if_grants,
    output logic [31:0]       stat_mem_grants,
    output logic [31:0]       stat_conflicts
);

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    arb_state_t        state_q, state_d;
    arb_port_t         port_q, grant_port;
    logic              grant;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [3:0]        cnt_q;
    logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;
    logic              if_ready_c, mem_ready_c;

    always_comb begin
        state_d     = state_q;
        grant       = 1'b0;
        grant_port  = ARB_PORT_IF;
        ram_en      = 1'b0;
        if_ready_c  = 1'b0;
        mem_ready_c = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (bus.mem_r_en || bus.mem_w_en) begin
                    grant      = 1'b1;
                    grant_port = ARB_PORT_MEM;
                    state_d    = ARB_ACCESS;
                end else if (bus.if_req) begin
                    grant   = 1'b1;
                    state_d = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                ram_en = 1'b1;
                if (cnt_q == LAST_CNT) state_d = ARB_RESP;
            end
            ARB_RESP: begin
                if (port_q == ARB_PORT_MEM) mem_ready_c = 1'b1;
                else                        if_ready_c  = 1'b1;
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            port_q      <= ARB_PORT_IF;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                // Request lines may change after the grant; the access runs on these latches.
                port_q  <= grant_port;
                addr_q  <= (grant_port == ARB_PORT_MEM) ? bus.mem_addr : bus.if_addr;
                wdata_q <= bus.mem_wdata;
                we_q    <= (grant_port == ARB_PORT_MEM) && bus.mem_w_en;
                cnt_q   <= '0;
            end else if (state_q == ARB_ACCESS) begin
                cnt_q <= cnt_q + 4'd1;
                if (cnt_q == LAST_CNT && !we_q) begin
                    if (port_q == ARB_PORT_MEM) mem_rdata_q <= ram_rdata;
                    else                        if_rdata_q  <= ram_rdata;
                end
            end
        end
    end

    assign ram_we    = ram_en && we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.if_ready  = if_ready_c;
    assign bus.mem_ready = mem_ready_c;
    assign bus.freeze    = (bus.mem_r_en || bus.mem_w_en) && !mem_ready_c;

`ifdef MEM_PORT_ARB_STATS_EN
    logic if_grant, mem_grant, if_conflict;

    assign if_grant  = grant && (grant_port == ARB_PORT_IF);
    assign mem_grant = grant && (grant_port == ARB_PORT_MEM);
    // A fetch is only "served" on its own grant cycle or while its access is in flight.
    assign if_conflict = bus.if_req &&
                         !(if_grant || (state_q != ARB_IDLE && port_q == ARB_PORT_IF));

    mem_port_arb_stats u_stats (
        .clk             (clk),
        .rst             (rst),
        .if_grant        (if_grant),
        .mem_grant       (mem_grant),
        .if_conflict     (if_conflict),
        .stat_if_grants  (stat_if_grants),
        .stat_mem_grants (stat_mem_grants),
        .stat_conflicts  (stat_conflicts)
    );
`else
    assign stat_if_grants  = '0;
    assign stat_mem_grants = '0;
    assign stat_conflicts  = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (WAIT_CYCLES=2) with a fixed-latency memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_en, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [31:0] stat_if_grants, stat_mem_grants, stat_conflicts;

    int checks   = 0;
    int failures = 0;
    int lat;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .ram_en          (ram_en),
        .ram_we          (ram_we),
        .ram_addr        (ram_addr),
        .ram_wdata       (ram_wdata),
        .ram_rdata       (ram_rdata),
        .stat_if_grants  (stat_if_grants),
        .stat_mem_grants (stat_mem_grants),
        .stat_conflicts  (stat_conflicts)
    );

    // Memory model: preset contents until a word is written
    logic [31:0] ram_mem [0:1023];
    logic        written [0:1023] = '{default: 1'b0};

    function automatic logic [31:0] preset(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'hAAAA_0000;
            32'h0000_0004: return 32'hBBBB_0004;
            32'h0000_0010: return 32'hE3A0_0001;
            32'h0000_0020: return 32'h3333_4444;
            32'h0000_0400: return 32'h1111_2222;
            default:       return 32'h0;
        endcase
    endfunction

    always_comb begin
        ram_rdata = preset({ram_addr[31:2], 2'b00});
        if (written[ram_addr[11:2]]) ram_rdata = ram_mem[ram_addr[11:2]];
    end

    always @(posedge clk) begin
        if (ram_en && ram_we) begin
            ram_mem[ram_addr[11:2]] <= ram_wdata;
            written[ram_addr[11:2]] <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_op(input logic w, input logic [31:0] addr, input logic [31:0] wd,
                          output int l);
        bus.mem_r_en  = !w;
        bus.mem_w_en  = w;
        bus.mem_addr  = addr;
        bus.mem_wdata = wd;
        l = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.mem_ready) begin
                l = c;
                break;
            end
            next_cycle();
        end
        next_cycle();
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.mem_r_en  = 1'b0;
        bus.mem_w_en  = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_ram_en",    ram_en,        0);
        chk("rst_ram_we",    ram_we,        0);
        chk("rst_ram_addr",  ram_addr,      0);
        chk("rst_if_ready",  bus.if_ready,  0);
        chk("rst_mem_ready", bus.mem_ready, 0);
        chk("rst_if_rdata",  bus.if_rdata,  0);
        chk("rst_mem_rdata", bus.mem_rdata, 0);
        chk("rst_freeze",    bus.freeze,    0);
        next_cycle();
        rst = 1'b0;

        // 1: IF-only fetch
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("s1_ram_en_c%0d", c),    ram_en,        (c == 1 || c == 2));
            chk($sformatf("s1_ram_we_c%0d", c),    ram_we,        0);
            chk($sformatf("s1_if_ready_c%0d", c),  bus.if_ready,  (c == 3));
            chk($sformatf("s1_mem_ready_c%0d", c), bus.mem_ready, 0);
            next_cycle();
            if (c == 3) bus.if_req = 1'b0;
        end
        chk("s1_if_rdata", bus.if_rdata, 32'hE3A0_0001);

        // 2: simultaneous IF and MEM, MEM wins; stats checked afterwards
        do_reset();
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h20;
        bus.mem_r_en = 1'b1;
        bus.mem_addr = 32'h400;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("s2_ram_en_c%0d", c), ram_en, (c == 1 || c == 2 || c == 5 || c == 6));
            if (ram_en)
                chk($sformatf("s2_ram_addr_c%0d", c), ram_addr, (c <= 2) ? 32'h400 : 32'h20);
            chk($sformatf("s2_mem_ready_c%0d", c), bus.mem_ready, (c == 3));
            chk($sformatf("s2_if_ready_c%0d", c),  bus.if_ready,  (c == 7));
            chk($sformatf("s2_freeze_c%0d", c),    bus.freeze,    (c <= 2));
            next_cycle();
            if (c == 3) bus.mem_r_en = 1'b0;
            if (c == 7) bus.if_req   = 1'b0;
        end
        chk("s2_mem_rdata", bus.mem_rdata, 32'h1111_2222);
        chk("s2_if_rdata",  bus.if_rdata,  32'h3333_4444);
`ifdef MEM_PORT_ARB_STATS_EN
        chk("s6_if_grants",  stat_if_grants,  32'd1);
        chk("s6_mem_grants", stat_mem_grants, 32'd1);
        chk("s6_conflicts",  stat_conflicts,  32'd4);
`else
        chk("s6_if_grants",  stat_if_grants,  32'd0);
        chk("s6_mem_grants", stat_mem_grants, 32'd0);
        chk("s6_conflicts",  stat_conflicts,  32'd0);
`endif

        // 3: store with stable address/data, load data untouched, then readback
        bus.mem_w_en  = 1'b1;
        bus.mem_addr  = 32'h404;
        bus.mem_wdata = 32'hDEAD_BEEF;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("s3_ram_we_c%0d", c),    ram_we,        (c == 1 || c == 2));
            chk($sformatf("s3_mem_ready_c%0d", c), bus.mem_ready, (c == 3));
            if (ram_en) begin
                chk($sformatf("s3_ram_addr_c%0d", c),  ram_addr,  32'h404);
                chk($sformatf("s3_ram_wdata_c%0d", c), ram_wdata, 32'hDEAD_BEEF);
            end
            next_cycle();
            if (c == 0) bus.mem_wdata = 32'h0BAD_0BAD;
            if (c == 3) bus.mem_w_en  = 1'b0;
        end
        chk("s3_mem_rdata_kept", bus.mem_rdata, 32'h1111_2222);
        mem_op(1'b0, 32'h404, 32'h0, lat);
        chk("s3_readback_lat",  32'(lat),      32'd3);
        chk("s3_readback_data", bus.mem_rdata, 32'hDEAD_BEEF);

        // both enables set: the write wins
        bus.mem_r_en  = 1'b1;
        bus.mem_w_en  = 1'b1;
        bus.mem_addr  = 32'h408;
        bus.mem_wdata = 32'hA5A5_A5A5;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("s3b_ram_we_c%0d", c),    ram_we,        (c == 1 || c == 2));
            chk($sformatf("s3b_mem_ready_c%0d", c), bus.mem_ready, (c == 3));
            next_cycle();
        end
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
        chk("s3b_mem_rdata_kept", bus.mem_rdata, 32'hDEAD_BEEF);
        mem_op(1'b0, 32'h408, 32'h0, lat);
        chk("s3b_readback_data", bus.mem_rdata, 32'hA5A5_A5A5);

        // 4: reset in the middle of a MEM read
        bus.mem_r_en = 1'b1;
        bus.mem_addr = 32'h400;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("s4_ram_en_c%0d", c),    ram_en,        (c == 1 || c == 2));
            chk($sformatf("s4_mem_ready_c%0d", c), bus.mem_ready, 0);
            next_cycle();
            if (c == 1) rst = 1'b1;
            if (c == 2) begin
                rst          = 1'b0;
                bus.mem_r_en = 1'b0;
            end
        end
        chk("s4_mem_rdata_cleared", bus.mem_rdata, 32'h0);
        mem_op(1'b0, 32'h400, 32'h0, lat);
        chk("s4_rereq_lat",  32'(lat),      32'd3);
        chk("s4_rereq_data", bus.mem_rdata, 32'h1111_2222);

        // 5: back-to-back MEM loads starve IF
        bus.mem_r_en = 1'b1;
        bus.mem_addr = 32'h0;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h10;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            chk($sformatf("s5_mem_ready_c%0d", c), bus.mem_ready, (c == 3 || c == 7));
            chk($sformatf("s5_if_ready_c%0d", c),  bus.if_ready,  (c == 11));
            if (c == 4) chk("s5_first_load", bus.mem_rdata, 32'hAAAA_0000);
            if (c == 5) chk("s5_second_addr", ram_addr, 32'h4);
            next_cycle();
            if (c == 3)  bus.mem_addr = 32'h4;
            if (c == 7)  bus.mem_r_en = 1'b0;
            if (c == 11) bus.if_req   = 1'b0;
        end
        chk("s5_second_load", bus.mem_rdata, 32'hBBBB_0004);
        chk("s5_if_rdata",    bus.if_rdata,  32'hE3A0_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
